// File: rtl/adc_if.sv
// ADC conversion handshake: the controller drives req, the converter answers with rdy/dat.
interface adc_if;
  logic       adc_req;
  logic       adc_rdy;
  logic [7:0] adc_dat;

  modport master (output adc_req, input adc_rdy, input adc_dat);
  modport slave  (input adc_req, output adc_rdy, output adc_dat);
endinterface

// File: rtl/adc_ctrl.sv
// Periodic ADC sequencer: triggers conversions, captures results, block-averages them
// and raises sticky timeout/overrun flags.
module adc_ctrl #(
  parameter int PERIOD   = 100,
  parameter int REQ_W    = 1,
  parameter int TIMEOUT  = 64,
  parameter int AVG_LOG2 = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       err_clr,
  adc_if.master      adc,
  output logic [7:0] sample,
  output logic       sample_vld,
  output logic [7:0] avg,
  output logic       avg_vld,
  output logic       err_timeout,
  output logic       err_overrun,
  output logic [1:0] state_o
);

  localparam int PW   = $clog2(PERIOD);
  localparam int TW   = $clog2(TIMEOUT);
  localparam int RW   = $clog2(REQ_W + 1);
  localparam int CW   = AVG_LOG2 + 1;
  localparam int ACCW = 8 + AVG_LOG2;

  localparam logic [PW-1:0] PMAX     = PW'(PERIOD - 1);
  localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] REQ_LAST = RW'(REQ_W - 1);
  localparam logic [CW-1:0] BLOCK    = CW'(2 ** AVG_LOG2);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_LO = 2'd2,
    WAIT_HI = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     timer_q, timer_d;
  logic [RW-1:0]     req_cnt_q, req_cnt_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [ACCW-1:0]   acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [7:0]        sample_q, sample_d;
  logic              sample_vld_q, sample_vld_d;
  logic [7:0]        avg_q, avg_d;
  logic              avg_vld_q, avg_vld_d;
  logic              err_timeout_q, err_timeout_d;
  logic              err_overrun_q, err_overrun_d;

  logic tick;
  logic capture;
  logic timeout;

  // A tick fires on the first enabled cycle and every PERIOD clocks after that.
  assign tick = en && (timer_q == '0);

  always_comb begin
    timer_d = '0;
    if (en) begin
      timer_d = (timer_q == PMAX) ? '0 : timer_q + PW'(1);
    end
  end

  // Handshake: req is held for REQ_W clocks; the converter acknowledges by
  // dropping rdy, then raising it again with dat valid for as long as rdy is high.
  always_comb begin
    state_d   = state_q;
    req_cnt_d = req_cnt_q;
    tcnt_d    = tcnt_q;
    capture   = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d   = REQ;
          req_cnt_d = '0;
        end
      end
      REQ: begin
        if (req_cnt_q == REQ_LAST) begin
          state_d = WAIT_LO;
          tcnt_d  = '0;
        end else begin
          req_cnt_d = req_cnt_q + RW'(1);
        end
      end
      WAIT_LO: begin
        if (tcnt_q == TMAX) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
          if (!adc.adc_rdy) state_d = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (adc.adc_rdy) begin
          capture = 1'b1;
          state_d = IDLE;
        end else if (tcnt_q == TMAX) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A completed block is flushed before a disable can discard it.
  always_comb begin
    sample_d     = sample_q;
    sample_vld_d = 1'b0;
    avg_d        = avg_q;
    avg_vld_d    = 1'b0;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    if (capture) begin
      sample_d     = adc.adc_dat;
      sample_vld_d = 1'b1;
      acc_d        = acc_q + ACCW'(adc.adc_dat);
      cnt_d        = cnt_q + CW'(1);
    end else if (cnt_q == BLOCK) begin
      avg_d     = acc_q[AVG_LOG2+7:AVG_LOG2];
      avg_vld_d = 1'b1;
      acc_d     = '0;
      cnt_d     = '0;
    end else if (!en && state_q == IDLE) begin
      acc_d = '0;
      cnt_d = '0;
    end
  end

  always_comb begin
    err_timeout_d = timeout | (err_timeout_q & ~err_clr);
    err_overrun_d = (tick && state_q != IDLE) | (err_overrun_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      req_cnt_q     <= '0;
      tcnt_q        <= '0;
      acc_q         <= '0;
      cnt_q         <= '0;
      sample_q      <= '0;
      sample_vld_q  <= 1'b0;
      avg_q         <= '0;
      avg_vld_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      req_cnt_q     <= req_cnt_d;
      tcnt_q        <= tcnt_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      sample_q      <= sample_d;
      sample_vld_q  <= sample_vld_d;
      avg_q         <= avg_d;
      avg_vld_q     <= avg_vld_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign adc.adc_req  = (state_q == REQ);
  assign sample       = sample_q;
  assign sample_vld   = sample_vld_q;
  assign avg          = avg_q;
  assign avg_vld      = avg_vld_q;
  assign err_timeout  = err_timeout_q;
  assign err_overrun  = err_overrun_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_adc_ctrl.sv
// Directed bench for adc_ctrl: main instance (TIMEOUT=8) plus a slow-ADC instance
// (TIMEOUT=64) for the overrun scenario.
module tb_adc_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0, err_clr = 1'b0;
  logic en2 = 1'b0, err_clr2 = 1'b0;

  logic [7:0] sample, avg, sample2, avg2;
  logic       sample_vld, avg_vld, err_timeout, err_overrun;
  logic       sample_vld2, avg_vld2, err_timeout2, err_overrun2;
  logic [1:0] state, state2;

  logic [7:0] adc_data_q[$];
  logic [7:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  bit adc_mute = 1'b0;

  adc_if a1();
  adc_if a2();

  always #5 clk = ~clk;

  adc_ctrl #(.PERIOD(20), .REQ_W(2), .TIMEOUT(8), .AVG_LOG2(2)) u_dut (
    .clk(clk), .rst(rst), .en(en), .err_clr(err_clr), .adc(a1),
    .sample(sample), .sample_vld(sample_vld), .avg(avg), .avg_vld(avg_vld),
    .err_timeout(err_timeout), .err_overrun(err_overrun), .state_o(state)
  );

  adc_ctrl #(.PERIOD(20), .REQ_W(2), .TIMEOUT(64), .AVG_LOG2(2)) u_dut2 (
    .clk(clk), .rst(rst), .en(en2), .err_clr(err_clr2), .adc(a2),
    .sample(sample2), .sample_vld(sample_vld2), .avg(avg2), .avg_vld(avg_vld2),
    .err_timeout(err_timeout2), .err_overrun(err_overrun2), .state_o(state2)
  );

  // ADC model: drops rdy one cycle after req rises, raises rdy with data 3 cycles after req falls.
  bit         m1_prev = 1'b0;
  int         m1_cnt  = -1;
  logic       m1_rdy  = 1'b1;
  logic [7:0] m1_dat  = 8'h00;
  assign a1.adc_rdy = m1_rdy;
  assign a1.adc_dat = m1_dat;

  always @(posedge clk) begin
    m1_prev <= a1.adc_req;
    if (a1.adc_req && !m1_prev) begin
      m1_rdy <= 1'b0;
      m1_cnt <= -1;
    end else if (!a1.adc_req && m1_prev) begin
      m1_cnt <= adc_mute ? -1 : 1;
    end else if (m1_cnt > 0) begin
      m1_cnt <= m1_cnt - 1;
    end else if (m1_cnt == 0) begin
      m1_rdy <= 1'b1;
      if (adc_data_q.size() > 0) m1_dat <= adc_data_q.pop_front();
      else m1_dat <= 8'hee;
      m1_cnt <= -1;
    end
  end

  // Slow ADC model: answers 25 cycles after req falls, always with 77.
  bit         m2_prev = 1'b0;
  int         m2_cnt  = -1;
  logic       m2_rdy  = 1'b1;
  logic [7:0] m2_dat  = 8'h00;
  assign a2.adc_rdy = m2_rdy;
  assign a2.adc_dat = m2_dat;

  always @(posedge clk) begin
    m2_prev <= a2.adc_req;
    if (a2.adc_req && !m2_prev) begin
      m2_rdy <= 1'b0;
      m2_cnt <= -1;
    end else if (!a2.adc_req && m2_prev) begin
      m2_cnt <= 23;
    end else if (m2_cnt > 0) begin
      m2_cnt <= m2_cnt - 1;
    end else if (m2_cnt == 0) begin
      m2_rdy <= 1'b1;
      m2_dat <= 8'd77;
      m2_cnt <= -1;
    end
  end

  task automatic test_reset();
    logic [28:0] obs;
    rst = 1'b1;
    en  = 1'b0;
    en2 = 1'b0;
    repeat (3) @(negedge clk);
    obs = {state, a1.adc_req, sample, sample_vld, avg, avg_vld, err_timeout, err_overrun, 6'd0};
    n_vec++;
    if (obs !== '0) begin
      n_err++;
      $display("FAIL reset_dut: got %h expected 0", obs);
    end
    obs = {state2, a2.adc_req, sample2, sample_vld2, avg2, avg_vld2, err_timeout2, err_overrun2, 6'd0};
    n_vec++;
    if (obs !== '0) begin
      n_err++;
      $display("FAIL reset_dut2: got %h expected 0", obs);
    end
    rst = 1'b0;
  endtask

  task automatic test_first_conv();
    int rise1, rise2, req_len, sv_k, sv_n;
    logic [7:0] sv_val, want;
    bit prev;
    rise1 = -1; rise2 = -1; req_len = 0; sv_k = -1; sv_n = 0; sv_val = 8'h00; prev = 1'b0;
    adc_data_q.push_back(8'd10);
    exp_q.push_back(8'd10);
    en = 1'b1;
    for (int k = 1; k <= 40 && rise2 < 0; k++) begin
      @(negedge clk);
      if (a1.adc_req && !prev) begin
        if (rise1 < 0) rise1 = k;
        else rise2 = k;
      end
      if (a1.adc_req && rise2 < 0) req_len++;
      if (sample_vld) begin
        sv_n++;
        sv_k = k;
        sv_val = sample;
      end
      prev = a1.adc_req;
    end
    n_vec++;
    if (rise1 != 1) begin n_err++; $display("FAIL first_req_start: got %0d expected 1", rise1); end
    n_vec++;
    if (req_len != 2) begin n_err++; $display("FAIL req_width: got %0d expected 2", req_len); end
    n_vec++;
    if (sv_n != 1) begin n_err++; $display("FAIL first_sample_pulses: got %0d expected 1", sv_n); end
    n_vec++;
    if (sv_k != 7) begin n_err++; $display("FAIL first_sample_cycle: got %0d expected 7", sv_k); end
    want = exp_q.pop_front();
    n_vec++;
    if (sv_val !== want) begin n_err++; $display("FAIL first_sample_value: got %0d expected %0d", sv_val, want); end
    n_vec++;
    if (rise2 < 0 || rise2 - rise1 != 20) begin
      n_err++;
      $display("FAIL req_period: got %0d expected 20", rise2 - rise1);
    end
  endtask

  task automatic test_average();
    logic [7:0] vals [7] = '{8'd11, 8'd12, 8'd14, 8'd40, 8'd40, 8'd40, 8'd44};
    logic [7:0] avg_exp [2] = '{8'd11, 8'd41};
    logic [7:0] want;
    int n_s, n_av, last_sv;
    n_s = 0; n_av = 0; last_sv = -1;
    foreach (vals[i]) begin
      adc_data_q.push_back(vals[i]);
      exp_q.push_back(vals[i]);
    end
    for (int k = 1; k <= 200 && n_av < 2; k++) begin
      @(negedge clk);
      if (sample_vld) begin
        n_s++;
        last_sv = k;
        want = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        n_vec++;
        if (sample !== want) begin n_err++; $display("FAIL avg_sample: got %0d expected %0d", sample, want); end
      end
      if (avg_vld) begin
        n_vec++;
        if (avg !== avg_exp[n_av]) begin n_err++; $display("FAIL avg_value: got %0d expected %0d", avg, avg_exp[n_av]); end
        n_vec++;
        if (k != last_sv + 1) begin n_err++; $display("FAIL avg_latency: got %0d expected 1", k - last_sv); end
        n_av++;
      end
    end
    n_vec++;
    if (n_av != 2 || n_s != 7) begin
      n_err++;
      $display("FAIL avg_counts: got %0d samples %0d avgs expected 7 samples 2 avgs", n_s, n_av);
    end
  endtask

  task automatic test_timeout();
    int f, n_sv;
    bit prev, seen;
    logic [7:0] want;
    adc_mute = 1'b1;
    f = -1; n_sv = 0; prev = a1.adc_req;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (sample_vld) n_sv++;
      if (f < 0 && prev && !a1.adc_req) f = k;
      if (f >= 0 && k == f + 7) begin
        n_vec++;
        if (err_timeout !== 1'b0) begin n_err++; $display("FAIL timeout_early: got %b expected 0", err_timeout); end
      end
      if (f >= 0 && k == f + 8) begin
        n_vec++;
        if (err_timeout !== 1'b1) begin n_err++; $display("FAIL timeout_set: got %b expected 1", err_timeout); end
        break;
      end
      prev = a1.adc_req;
    end
    n_vec++;
    if (f < 0) begin n_err++; $display("FAIL timeout_req_seen: got none expected a request"); end
    n_vec++;
    if (n_sv != 0) begin n_err++; $display("FAIL timeout_no_sample: got %0d expected 0", n_sv); end
    adc_mute = 1'b0;
    adc_data_q.push_back(8'd50);
    exp_q.push_back(8'd50);
    seen = 1'b0;
    prev = a1.adc_req;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (a1.adc_req && !prev) begin seen = 1'b1; break; end
      prev = a1.adc_req;
    end
    n_vec++;
    if (!seen) begin n_err++; $display("FAIL timeout_next_req: got none expected a request"); end
    seen = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (sample_vld) begin seen = 1'b1; break; end
    end
    want = exp_q.pop_front();
    n_vec++;
    if (!seen || sample !== want) begin
      n_err++;
      $display("FAIL post_timeout_sample: got %0d expected %0d", sample, want);
    end
    n_vec++;
    if (err_timeout !== 1'b1) begin n_err++; $display("FAIL timeout_sticky: got %b expected 1", err_timeout); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_vec++;
    if (err_timeout !== 1'b0) begin n_err++; $display("FAIL timeout_clear: got %b expected 0", err_timeout); end
  endtask

  task automatic test_reset_mid();
    logic [22:0] obs;
    bit seen;
    int n_sv;
    adc_data_q.push_back(8'd60);
    seen = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (state == 2'd3) begin seen = 1'b1; break; end
    end
    n_vec++;
    if (!seen) begin n_err++; $display("FAIL reach_wait_hi: got none expected WAIT_HI"); end
    rst = 1'b1;
    en  = 1'b0;
    @(negedge clk);
    obs = {state, a1.adc_req, sample, sample_vld, avg, avg_vld, err_timeout, err_overrun};
    n_vec++;
    if (obs !== '0) begin n_err++; $display("FAIL mid_reset_state: got %h expected 0", obs); end
    rst = 1'b0;
    n_sv = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (sample_vld) n_sv++;
    end
    n_vec++;
    if (n_sv != 0) begin n_err++; $display("FAIL late_rdy_ignored: got %0d expected 0", n_sv); end
  endtask

  task automatic test_disable();
    logic [7:0] vals [6] = '{8'd30, 8'd30, 8'd20, 8'd20, 8'd20, 8'd20};
    logic [7:0] want;
    int n_s, n_av;
    n_s = 0; n_av = 0;
    foreach (vals[i]) begin
      adc_data_q.push_back(vals[i]);
      exp_q.push_back(vals[i]);
    end
    en = 1'b1;
    for (int k = 1; k <= 200 && (n_s < 6 || n_av < 1); k++) begin
      @(negedge clk);
      if (avg_vld) begin
        n_av++;
        n_vec++;
        if (avg !== 8'd20) begin n_err++; $display("FAIL partial_discard_avg: got %0d expected 20", avg); end
      end
      if (sample_vld) begin
        n_s++;
        want = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        n_vec++;
        if (sample !== want) begin n_err++; $display("FAIL disable_sample: got %0d expected %0d", sample, want); end
        if (n_s == 2) begin
          en = 1'b0;
          repeat (5) begin
            @(negedge clk);
            if (avg_vld) n_av++;
          end
          en = 1'b1;
        end
      end
    end
    n_vec++;
    if (n_s != 6 || n_av != 1) begin
      n_err++;
      $display("FAIL disable_counts: got %0d samples %0d avgs expected 6 samples 1 avg", n_s, n_av);
    end
    en = 1'b0;
  endtask

  task automatic test_overrun();
    int r1, r2, sv_n, sv_k;
    logic [7:0] sv_val;
    bit prev;
    r1 = -1; r2 = -1; sv_n = 0; sv_k = -1; sv_val = 8'h00; prev = 1'b0;
    en2 = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k == 20) begin
        n_vec++;
        if (err_overrun2 !== 1'b0) begin n_err++; $display("FAIL overrun_early: got %b expected 0", err_overrun2); end
        err_clr2 = 1'b1;
      end
      if (k == 21) begin
        err_clr2 = 1'b0;
        n_vec++;
        if (err_overrun2 !== 1'b1) begin n_err++; $display("FAIL overrun_set_wins: got %b expected 1", err_overrun2); end
      end
      if (a2.adc_req && !prev) begin
        if (r1 < 0) r1 = k;
        else if (r2 < 0) r2 = k;
      end
      if (sample_vld2) begin
        sv_n++;
        sv_k = k;
        sv_val = sample2;
      end
      prev = a2.adc_req;
    end
    en2 = 1'b0;
    n_vec++;
    if (r1 != 1) begin n_err++; $display("FAIL overrun_first_req: got %0d expected 1", r1); end
    n_vec++;
    if (r2 < 0 || r2 - r1 != 40) begin n_err++; $display("FAIL overrun_next_req: got %0d expected 40", r2 - r1); end
    n_vec++;
    if (sv_n != 1 || sv_k != 29) begin n_err++; $display("FAIL overrun_sample_cycle: got %0d pulses at %0d expected 1 at 29", sv_n, sv_k); end
    n_vec++;
    if (sv_val !== 8'd77) begin n_err++; $display("FAIL overrun_sample_value: got %0d expected 77", sv_val); end
    n_vec++;
    if (err_timeout2 !== 1'b0) begin n_err++; $display("FAIL overrun_no_timeout: got %b expected 0", err_timeout2); end
    err_clr2 = 1'b1;
    @(negedge clk);
    err_clr2 = 1'b0;
    n_vec++;
    if (err_overrun2 !== 1'b0) begin n_err++; $display("FAIL overrun_clear: got %b expected 0", err_overrun2); end
  endtask

  initial begin
    test_reset();
    test_first_conv();
    test_average();
    test_timeout();
    test_reset_mid();
    test_disable();
    test_overrun();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
